mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Load/store sequencer directly upstream of Data_Memory; executes LOAD (RF[ra] <= D[d])
//   and STORE (D[d] <= RF[ra]) for the six-instruction processor.
// - Takes one request from the controller, drives Data_Memory addr/rd/wr/W_data, captures
//   R_data and issues the register-file write-back. Controller waits on done.
// PARAMETERS
// - ADDR_W   8   data-memory address width (D_addr, req_d)
// - DATA_W   16  data word width
// - RF_AW    4   register-file index width (16 registers)
// - RD_WAIT  1   extra cycles D_rd is held before R_data is captured (0 = capture in first rd cycle)
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       async active-low reset
// - req_valid   in   1       controller request present
// - req_ready   out  1       1 only in IDLE; accept = req_valid & req_ready at a clk edge
// - req_op      in   1       0 = LOAD, 1 = STORE
// - req_d       in   ADDR_W  data-memory address
// - req_ra      in   RF_AW   register index (LOAD dest; STORE data source, informational)
// - st_data     in   DATA_W  RF[ra] read data, sampled at accept (STORE only)
// - D_addr      out  ADDR_W  to Data_Memory addr
// - D_rd        out  1       to Data_Memory rd
// - D_wr        out  1       to Data_Memory wr
// - D_W_data    out  DATA_W  to Data_Memory W_data
// - D_R_data    in   DATA_W  from Data_Memory R_data
// - RF_W_addr   out  RF_AW   register-file write index
// - RF_W_wr     out  1       register-file write strobe, 1 cycle
// - RF_W_data   out  DATA_W  register-file write data
// - done        out  1       1-cycle pulse on completion
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; D_rd=D_wr=RF_W_wr=done=0; D_addr, D_W_data,
//   RF_W_addr, RF_W_data, capture regs, wait counter = 0. req_ready=1 once in IDLE.
// - States: IDLE, LD_RD, LD_WB, ST_WR. All outputs decoded from registered state/regs; no
//   combinational path from req_* to D_* / RF_*.
// - Accept at edge T: latch req_d, req_ra, st_data. op=0 -> LD_RD; op=1 -> ST_WR.
// - LD_RD: D_rd=1, D_addr=d for RD_WAIT+1 cycles (T+1 .. T+1+RD_WAIT); D_R_data captured at
//   the end of the last one -> LD_WB.
// - LD_WB (T+2+RD_WAIT): RF_W_wr=1, RF_W_addr=ra, RF_W_data=captured, done=1 -> IDLE.
// - ST_WR (T+1): D_wr=1, D_addr=d, D_W_data=latched st_data, done=1, exactly 1 cycle -> IDLE.
// - Latency accept->done: LOAD RD_WAIT+2 cycles, STORE 1 cycle. Min request spacing: one
//   IDLE cycle between operations, even with req_valid held high.
// - D_rd and D_wr never both 1; D_rd=D_wr=0 in IDLE and LD_WB; RF_W_wr only in LD_WB.
// - req_valid while busy is ignored; controller holds request until accepted.
// - Full 8-bit address range; no bounds check; address 255 legal.
// - Reset mid-operation: immediate return to IDLE, strobes drop asynchronously, no RF
//   write, no done. Store cut by reset: memory content at d undefined.
// STRUCTURE
// - Package mem_access_pkg: state encoding (IDLE, LD_RD, LD_WB, ST_WR), OP_LOAD=1'b0,
//   OP_STORE=1'b1, default widths.
// - Single module; RD_WAIT counter inline; no sub-module.
// TESTING (RD_WAIT=1 unless noted; memory preset mem[0]=3, mem[1]=12)
// - Reset: rst_n=0 mid-run -> all strobes 0 at once, req_ready=1 after release, no done.
// - LOAD d=0 ra=2 accepted at T -> D_rd=1 at T+1,T+2; RF_W_wr=1 addr=2 data=0x0003 and
//   done=1 at T+3.
// - STORE d=5 st_data=0x00AB -> D_wr=1 addr=5 data=0x00AB, done at T+1; then LOAD d=5 ra=7
//   -> RF_W_data=0x00AB, RF_W_addr=7.
// - Back-to-back: req_valid held, LOAD d=1 then STORE d=255 -> 0x000C written back, one IDLE
//   gap, D_wr at addr 255; D_rd&D_wr never 1.
// - Busy rejection: new request during LD_RD -> req_ready=0, ignored; original completes.
// - RD_WAIT=0 build: LOAD d=1 ra=15 -> single D_rd cycle, RF_W_data=0x000C at T+2.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the load/store sequencer that sits in front of Data_Memory.
package mem_access_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int RF_AW_DEF   = 4;
    localparam int RD_WAIT_DEF = 1;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LD_RD = 2'd1,
        LD_WB = 2'd2,
        ST_WR = 2'd3
    } state_t;

    // A zero read wait still needs a one-bit counter so the compare stays well formed.
    function automatic int cntWidth(input int waitCycles);
        return (waitCycles > 0) ? $clog2(waitCycles + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer: takes one controller request, drives Data_Memory and writes loads back to the RF.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RF_AW   = RF_AW_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_d,
    input  logic [RF_AW-1:0]  req_ra,
    input  logic [DATA_W-1:0] st_data,
    output logic [ADDR_W-1:0] D_addr,
    output logic              D_rd,
    output logic              D_wr,
    output logic [DATA_W-1:0] D_W_data,
    input  logic [DATA_W-1:0] D_R_data,
    output logic [RF_AW-1:0]  RF_W_addr,
    output logic              RF_W_wr,
    output logic [DATA_W-1:0] RF_W_data,
    output logic              done
);

    localparam int               CNT_W     = cntWidth(RD_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT);

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_rdLast;
    logic [ADDR_W-1:0]   r_addr;
    logic [RF_AW-1:0]    r_ra;
    logic [DATA_W-1:0]   r_stData;
    logic [DATA_W-1:0]   r_rdData;
    logic [CNT_W-1:0]    r_wait;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_rdLast = (r_wait == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = (req_op == OP_STORE) ? ST_WR : LD_RD;
                end
            end
            LD_RD: begin
                if (w_rdLast) begin
                    w_next = LD_WB;
                end
            end
            LD_WB:   w_next = IDLE;
            ST_WR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are latched at accept so the memory side never sees req_* change mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_ra     <= '0;
            r_stData <= '0;
            r_rdData <= '0;
            r_wait   <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_d;
                r_ra     <= req_ra;
                r_stData <= st_data;
                r_wait   <= '0;
            end
            if (r_state == LD_RD) begin
                if (w_rdLast) begin
                    r_rdData <= D_R_data;
                end else begin
                    r_wait <= r_wait + CNT_W'(1);
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign D_addr    = r_addr;
    assign D_rd      = (r_state == LD_RD);
    assign D_wr      = (r_state == ST_WR);
    assign D_W_data  = r_stData;
    assign RF_W_addr = r_ra;
    assign RF_W_wr   = (r_state == LD_WB);
    assign RF_W_data = r_rdData;
    assign done      = (r_state == LD_WB) || (r_state == ST_WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: RD_WAIT=1 instance for most scenarios, RD_WAIT=0 instance for the fast load.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic memClear = 1'b1;

    always #5 clk = ~clk;

    // Instance A (RD_WAIT=1)
    logic        aValid, aReady, aOp;
    logic [7:0]  aD, aAddr;
    logic [3:0]  aRa, aRfAddr;
    logic [15:0] aStData, aWData, aRData, aRfData;
    logic        aRd, aWr, aRfWr, aDone;

    // Instance B (RD_WAIT=0)
    logic        bValid, bReady, bOp;
    logic [7:0]  bD, bAddr;
    logic [3:0]  bRa, bRfAddr;
    logic [15:0] bStData, bWData, bRData, bRfData;
    logic        bRd, bWr, bRfWr, bDone;

    logic [15:0] memA [256];
    logic [15:0] memB [256];

    int nChecks = 0;
    int nPass   = 0;
    logic overlapSeen = 1'b0;

    mem_access_unit #(.ADDR_W(8), .DATA_W(16), .RF_AW(4), .RD_WAIT(1)) dutA (
        .clk(clk), .rst_n(rst_n),
        .req_valid(aValid), .req_ready(aReady), .req_op(aOp), .req_d(aD), .req_ra(aRa),
        .st_data(aStData), .D_addr(aAddr), .D_rd(aRd), .D_wr(aWr), .D_W_data(aWData),
        .D_R_data(aRData), .RF_W_addr(aRfAddr), .RF_W_wr(aRfWr), .RF_W_data(aRfData),
        .done(aDone)
    );

    mem_access_unit #(.ADDR_W(8), .DATA_W(16), .RF_AW(4), .RD_WAIT(0)) dutB (
        .clk(clk), .rst_n(rst_n),
        .req_valid(bValid), .req_ready(bReady), .req_op(bOp), .req_d(bD), .req_ra(bRa),
        .st_data(bStData), .D_addr(bAddr), .D_rd(bRd), .D_wr(bWr), .D_W_data(bWData),
        .D_R_data(bRData), .RF_W_addr(bRfAddr), .RF_W_wr(bRfWr), .RF_W_data(bRfData),
        .done(bDone)
    );

    assign aRData = memA[aAddr];
    assign bRData = memB[bAddr];

    // Data_Memory models: asynchronous read, synchronous write, preset while memClear is high
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 256; i++) begin
                memA[i] <= 16'h0000;
                memB[i] <= 16'h0000;
            end
            memA[0] <= 16'h0003;
            memA[1] <= 16'h000C;
            memB[0] <= 16'h0003;
            memB[1] <= 16'h000C;
        end else begin
            if (aWr) memA[aAddr] <= aWData;
            if (bWr) memB[bAddr] <= bWData;
        end
    end

    always @(negedge clk) begin
        if (aRd && aWr) overlapSeen <= 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    // Drive a request on instance A at the current negedge; it is accepted at the next posedge.
    task automatic applyStimulus(input logic op, input logic [7:0] d, input logic [3:0] ra,
                                 input logic [15:0] data);
        aValid  = 1'b1;
        aOp     = op;
        aD      = d;
        aRa     = ra;
        aStData = data;
    endtask

    initial begin
        aValid = 0; aOp = 0; aD = 0; aRa = 0; aStData = 0;
        bValid = 0; bOp = 0; bD = 0; bRa = 0; bStData = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_rd",     32'(aRd),     32'h0);
        checkOutput("rst_wr",     32'(aWr),     32'h0);
        checkOutput("rst_rfwr",   32'(aRfWr),   32'h0);
        checkOutput("rst_done",   32'(aDone),   32'h0);
        checkOutput("rst_addr",   32'(aAddr),   32'h0);
        checkOutput("rst_rfdata", 32'(aRfData), 32'h0);
        checkOutput("rst_ready",  32'(aReady),  32'h1);
        rst_n    = 1'b1;
        memClear = 1'b0;
        @(negedge clk);

        // LOAD d=0 ra=2
        applyStimulus(OP_LOAD, 8'd0, 4'd2, 16'h0);
        @(negedge clk);
        aValid = 0;
        checkOutput("ld0_rd1",    32'(aRd),     32'h1);
        checkOutput("ld0_addr",   32'(aAddr),   32'h0);
        checkOutput("ld0_busy",   32'(aReady),  32'h0);
        @(negedge clk);
        checkOutput("ld0_rd2",    32'(aRd),     32'h1);
        checkOutput("ld0_early",  32'(aDone),   32'h0);
        @(negedge clk);
        checkOutput("ld0_rfwr",   32'(aRfWr),   32'h1);
        checkOutput("ld0_rfaddr", 32'(aRfAddr), 32'h2);
        checkOutput("ld0_rfdata", 32'(aRfData), 32'h0003);
        checkOutput("ld0_done",   32'(aDone),   32'h1);
        checkOutput("ld0_wbrd",   32'(aRd),     32'h0);
        @(negedge clk);
        checkOutput("ld0_idle",   32'(aReady),  32'h1);
        checkOutput("ld0_rfoff",  32'(aRfWr),   32'h0);

        // STORE d=5 0x00AB, then LOAD it back into r7
        applyStimulus(OP_STORE, 8'd5, 4'd1, 16'h00AB);
        @(negedge clk);
        aValid = 0;
        checkOutput("st5_wr",     32'(aWr),     32'h1);
        checkOutput("st5_rd",     32'(aRd),     32'h0);
        checkOutput("st5_addr",   32'(aAddr),   32'h5);
        checkOutput("st5_data",   32'(aWData),  32'h00AB);
        checkOutput("st5_done",   32'(aDone),   32'h1);
        @(negedge clk);
        checkOutput("st5_wroff",  32'(aWr),     32'h0);
        checkOutput("st5_mem",    32'(memA[5]), 32'h00AB);
        applyStimulus(OP_LOAD, 8'd5, 4'd7, 16'h0);
        @(negedge clk);
        aValid = 0;
        repeat (2) @(negedge clk);
        checkOutput("ld5_rfwr",   32'(aRfWr),   32'h1);
        checkOutput("ld5_rfdata", 32'(aRfData), 32'h00AB);
        checkOutput("ld5_rfaddr", 32'(aRfAddr), 32'h7);
        @(negedge clk);

        // Back-to-back with req_valid held: LOAD d=1 ra=3, then STORE d=255
        applyStimulus(OP_LOAD, 8'd1, 4'd3, 16'h0);
        @(negedge clk);
        applyStimulus(OP_STORE, 8'd255, 4'd0, 16'h1234);
        checkOutput("b2b_rd",     32'(aRd),     32'h1);
        repeat (2) @(negedge clk);
        checkOutput("b2b_rfdata", 32'(aRfData), 32'h000C);
        checkOutput("b2b_rfaddr", 32'(aRfAddr), 32'h3);
        checkOutput("b2b_ldone",  32'(aDone),   32'h1);
        @(negedge clk);
        checkOutput("b2b_gap",    32'(aReady),  32'h1);
        checkOutput("b2b_gapwr",  32'(aWr),     32'h0);
        checkOutput("b2b_gapdn",  32'(aDone),   32'h0);
        @(negedge clk);
        aValid = 0;
        checkOutput("b2b_wr",     32'(aWr),     32'h1);
        checkOutput("b2b_addr",   32'(aAddr),   32'hFF);
        checkOutput("b2b_wdata",  32'(aWData),  32'h1234);
        @(negedge clk);
        checkOutput("b2b_mem",    32'(memA[255]), 32'h1234);
        checkOutput("b2b_wroff",  32'(aWr),     32'h0);

        // Busy rejection: a STORE offered during LD_RD must be ignored
        applyStimulus(OP_LOAD, 8'd0, 4'd4, 16'h0);
        @(negedge clk);
        applyStimulus(OP_STORE, 8'd9, 4'd0, 16'h0055);
        checkOutput("busy_ready", 32'(aReady),  32'h0);
        @(negedge clk);
        checkOutput("busy_rd",    32'(aRd),     32'h1);
        checkOutput("busy_nowr",  32'(aWr),     32'h0);
        @(negedge clk);
        aValid = 0;
        checkOutput("busy_rfaddr", 32'(aRfAddr), 32'h4);
        checkOutput("busy_rfdata", 32'(aRfData), 32'h0003);
        checkOutput("busy_done",   32'(aDone),   32'h1);
        @(negedge clk);
        checkOutput("busy_idle",  32'(aWr),     32'h0);
        checkOutput("busy_mem9",  32'(memA[9]), 32'h0);

        // Reset in the middle of a LOAD
        applyStimulus(OP_LOAD, 8'd1, 4'd5, 16'h0);
        @(negedge clk);
        aValid = 0;
        checkOutput("mid_rdpre",  32'(aRd),     32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rd",     32'(aRd),     32'h0);
        checkOutput("mid_rfwr",   32'(aRfWr),   32'h0);
        checkOutput("mid_done",   32'(aDone),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_ready",  32'(aReady),  32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mid_nodone", 32'(aDone),   32'h0);
            checkOutput("mid_norf",   32'(aRfWr),   32'h0);
        end

        // RD_WAIT=0 instance: LOAD d=1 ra=15
        bValid = 1; bOp = OP_LOAD; bD = 8'd1; bRa = 4'd15;
        @(negedge clk);
        bValid = 0;
        checkOutput("fast_rd",    32'(bRd),     32'h1);
        checkOutput("fast_early", 32'(bDone),   32'h0);
        @(negedge clk);
        checkOutput("fast_rdoff", 32'(bRd),     32'h0);
        checkOutput("fast_rfwr",  32'(bRfWr),   32'h1);
        checkOutput("fast_rfdata", 32'(bRfData), 32'h000C);
        checkOutput("fast_rfaddr", 32'(bRfAddr), 32'hF);
        checkOutput("fast_done",  32'(bDone),   32'h1);
        @(negedge clk);
        checkOutput("fast_idle",  32'(bReady),  32'h1);

        checkOutput("no_overlap", 32'(overlapSeen), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
